fetch_ctrl: RTL

//  PC generator and IF/ID front-end that sits directly downstream of the instruction buffer.

---
 rtl/scpu_pkg.sv | 18 +
 rtl/fetch_ctrl_if.sv | 12 +
 rtl/fetch_skid_q.sv | 46 ++++
 rtl/fetch_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/scpu_pkg.sv
// rtl/scpu_pkg.sv - shared front-end types and constants
package scpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    CAPT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch-to-decode valid/ready handshake
interface fetch_ctrl_if;

  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ins;
  logic [31:0] id_pc;

  modport master (output id_valid, output id_ins, output id_pc, input id_ready);
  modport slave  (input id_valid, input id_ins, input id_pc, output id_ready);

endinterface

// File: rtl/fetch_skid_q.sv
// rtl/fetch_skid_q.sv - 2-entry FIFO of {pc, ins}; flush wins over push/pop
module fetch_skid_q
  import scpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC generator and IF/ID front-end; optional FETCH_PERF_CNT_EN perf counters
module fetch_ctrl
  import scpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          FETCH_LAT = 2,
  parameter logic [31:0] NOP_INSTR = scpu_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  output logic [31:0]   pc_out,
  input  logic [31:0]   buf_ins,
  input  logic          buf_valid,
  input  logic          buf_busy,
  input  logic          redir_en,
  input  logic [31:0]   redir_pc,
  fetch_ctrl_if.master  id,
  output logic          misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall
`endif
);

  localparam logic [2:0] LAT_INIT = 3'(FETCH_LAT);

  fetch_state_t state, state_nxt;
  logic [2:0]   lat_cnt, lat_nxt;
  logic [31:0]  pc_nxt;
  logic         push, pop, full, empty, can_push;
  fetch_entry_t head;

  assign pop      = !empty && id.id_ready;
  assign can_push = buf_valid && !buf_busy && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= WAIT;
      lat_cnt  <= LAT_INIT;
      pc_out   <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_nxt;
      pc_out   <= pc_nxt;
      misalign <= redir_en && (|redir_pc[1:0]);
    end
  end

  // The last latency cycle and the move to CAPT share an edge, so one word
  // is captured every FETCH_LAT+1 cycles.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    pc_nxt    = pc_out;
    push      = 1'b0;
    case (state)
      WAIT: begin
        if (buf_busy || !buf_valid) begin
          lat_nxt = LAT_INIT;
        end else if (lat_cnt <= 3'd1) begin
          lat_nxt   = 3'd0;
          state_nxt = CAPT;
        end else begin
          lat_nxt = lat_cnt - 3'd1;
        end
      end
      CAPT: begin
        if (can_push) begin
          push      = 1'b1;
          pc_nxt    = pc_out + 32'd4;
          lat_nxt   = LAT_INIT;
          state_nxt = WAIT;
        end
      end
      FLUSH: state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
    if (redir_en) begin
      push      = 1'b0;
      state_nxt = FLUSH;
      pc_nxt    = {redir_pc[31:2], 2'b00};
      lat_nxt   = LAT_INIT;
    end
  end

  fetch_skid_q u_q (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redir_en),
    .wr_data ('{pc: pc_out, ins: buf_ins}),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign id.id_valid = !empty;
  assign id.id_ins   = empty ? NOP_INSTR : head.ins;
  assign id.id_pc    = empty ? 32'd0 : head.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (push)  perf_fetched <= perf_fetched + 32'd1;
      if (empty) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
